// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// instruction field positions and the default program address width.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 8;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 4;
  localparam int RD_HI   = 3;
  localparam int RD_LO   = 2;
  localparam int RS_HI   = 1;
  localparam int RS_LO   = 0;
  localparam int IMM4_HI = 3;
  localparam int IMM2_HI = 1;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {address, instruction} pairs with flush.
// The head is read combinationally so the consumer sees it in the same cycle.
module fetch_queue #(
  parameter int AW    = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] push_addr,
  input  logic [7:0]    push_instr,
  output logic [AW-1:0] head_addr,
  output logic [7:0]    head_instr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] addr_mem  [DEPTH];
  logic [7:0]    instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      addr_mem[wr_ptr_reg]  <= push_addr;
      instr_mem[wr_ptr_reg] <= push_instr;
    end
  end

  assign head_addr  = addr_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];
  assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns program memory, prefetches into a small
// queue and hands decoded instructions to the control unit via valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [15:0]       load_data,
  input  logic              run,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              issue_ready,
  output logic              issue_valid,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [1:0]        imm2,
  output logic [3:0]        imm4,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(QDEPTH + 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] end_addr_reg;
  logic              prog_valid_reg;
  logic              first_wr_reg;
  logic [ADDR_W:0]   fpc_reg, fpc_next;
  logic              inflight_reg, inflight_next;
  logic [ADDR_W-1:0] inflight_addr_reg;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data_reg;

  logic              load_wr, fetch_en, slot_free, fpc_in_range, pipe_empty;
  logic [ADDR_W-1:0] load_addr;
  logic              q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0]     q_count;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_instr;

  assign load_addr    = load_data[8 +: ADDR_W];
  assign fpc_in_range = (fpc_reg <= {1'b0, end_addr_reg});
  assign pipe_empty   = q_empty && !inflight_reg;

  always_comb begin
    state_next    = state_reg;
    fpc_next      = fpc_reg;
    inflight_next = 1'b0;
    fetch_en      = 1'b0;
    q_flush       = 1'b0;
    q_push        = 1'b0;
    load_wr       = (state_reg == LOAD) && load_we;
    issue_valid   = (state_reg == RUN) && !q_empty;
    q_pop         = issue_valid && issue_ready;
    // A slot being popped this cycle can be refilled, giving 1 instr/cycle.
    slot_free     = (int'(q_count) + int'(inflight_reg)) < (QDEPTH + int'(q_pop));

    case (state_reg)
      IDLE: begin
        if (load_en)  state_next = LOAD;
        else if (run) state_next = prog_valid_reg ? RUN : HALT;
      end
      LOAD: begin
        if (!load_en) state_next = IDLE;
      end
      RUN: begin
        if (redirect_en) begin
          q_flush  = 1'b1;
          fpc_next = {1'b0, redirect_addr};
        end else begin
          q_push = inflight_reg && (!q_full || q_pop);
          if (!fpc_in_range && pipe_empty) begin
            state_next = HALT;
          end else begin
            fetch_en      = fpc_in_range && slot_free;
            inflight_next = fetch_en;
            if (fetch_en) fpc_next = fpc_reg + 1'b1;
          end
        end
      end
      HALT: begin
        if (load_en)  state_next = LOAD;
        else if (run) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase

    if (state_next == RUN && state_reg != RUN) begin
      fpc_next = '0;
      q_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      end_addr_reg      <= '0;
      prog_valid_reg    <= 1'b0;
      first_wr_reg      <= 1'b0;
      fpc_reg           <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fpc_reg      <= fpc_next;
      inflight_reg <= inflight_next;
      if (fetch_en) inflight_addr_reg <= fpc_reg[ADDR_W-1:0];
      if (state_next == LOAD && state_reg != LOAD) first_wr_reg <= 1'b1;
      if (load_wr) begin
        prog_valid_reg <= 1'b1;
        first_wr_reg   <= 1'b0;
        if (first_wr_reg || load_addr > end_addr_reg) end_addr_reg <= load_addr;
      end
    end
  end

  // Program memory: single write port for loading, registered fetch read.
  always_ff @(posedge clk) begin
    if (load_wr)  mem[load_addr] <= load_data[7:0];
    if (fetch_en) rd_data_reg <= mem[fpc_reg[ADDR_W-1:0]];
  end

  fetch_queue #(
    .AW    (ADDR_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (q_flush),
    .push_addr  (inflight_addr_reg),
    .push_instr (rd_data_reg),
    .head_addr  (head_addr),
    .head_instr (head_instr),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  // Fields are qualified by valid so idle/reset outputs read as zero.
  assign opcode = issue_valid ? head_instr[OP_HI:OP_LO]  : '0;
  assign rd     = issue_valid ? head_instr[RD_HI:RD_LO]  : '0;
  assign rs     = issue_valid ? head_instr[RS_HI:RS_LO]  : '0;
  assign imm2   = issue_valid ? head_instr[IMM2_HI:0]    : '0;
  assign imm4   = issue_valid ? head_instr[IMM4_HI:0]    : '0;
  assign pc_out = issue_valid ? head_addr : '0;
  assign halted = (state_reg == HALT);
  assign busy   = (state_reg == LOAD) || (state_reg == RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected transfers,
// a negedge monitor pops and compares every valid&&ready handshake.
module tb_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int QDEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_en = 1'b0, load_we = 1'b0;
  logic [15:0]       load_data = '0;
  logic              run = 1'b0, redirect_en = 1'b0, issue_ready = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              issue_valid, halted, busy;
  logic [3:0]        opcode, imm4;
  logic [1:0]        rd, rs, imm2;
  logic [ADDR_W-1:0] pc_out;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .load_we       (load_we),
    .load_data     (load_data),
    .run           (run),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .issue_ready   (issue_ready),
    .issue_valid   (issue_valid),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .imm2          (imm2),
    .imm4          (imm4),
    .pc_out        (pc_out),
    .halted        (halted),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: got pc=%02h op=%0h expected none", pc_out, opcode);
      end else begin
        exp_t e;
        logic [7:0] ei;
        e  = sb.pop_front();
        ei = e.instr;
        $display("xfer pc=%02h op=%0h rd=%0d rs=%0d imm4=%0h (want pc=%02h instr=%02h)",
                 pc_out, opcode, rd, rs, imm4, e.pc, e.instr);
        check("xfer_pc",   32'(pc_out), 32'(e.pc));
        check("xfer_op",   32'(opcode), 32'(ei[7:4]));
        check("xfer_rd",   32'(rd),     32'(ei[3:2]));
        check("xfer_rs",   32'(rs),     32'(ei[1:0]));
        check("xfer_imm2", 32'(imm2),   32'(ei[1:0]));
        check("xfer_imm4", 32'(imm4),   32'(ei[3:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [7:0] pc, input logic [7:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic load_begin();
    load_en = 1'b1;
    tick();
    check("busy_in_load", 32'(busy), 32'd1);
  endtask

  task automatic load_write(input logic [7:0] a, input logic [7:0] d);
    load_we = 1'b1;
    load_data = {a, d};
    tick();
  endtask

  task automatic load_end();
    load_we = 1'b0;
    load_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  logic [7:0] prog [4];

  initial begin
    prog[0] = 8'h21; prog[1] = 8'h36; prog[2] = 8'h47; prog[3] = 8'h9E;

    // Reset state
    #12;
    check("rst_valid",  32'(issue_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_pc",     32'(pc_out), 32'd0);
    rst = 1'b0;
    tick();

    // 1: load and run at full throughput
    load_begin();
    for (int i = 0; i < 4; i++) load_write(8'(i), prog[i]);
    load_end();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_xfer(8'(i), prog[i]);
    start_run();
    check("t1_busy_run", 32'(busy), 32'd1);
    check("t1_lat0", 32'(issue_valid), 32'd0);
    tick();
    check("t1_lat1", 32'(issue_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", 32'(issue_valid), 32'd1);
      check("t1_pc",    32'(pc_out), 32'(k));
      tick();
    end
    check("t1_drain_valid",  32'(issue_valid), 32'd0);
    check("t1_drain_halted", 32'(halted), 32'd0);
    tick();
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: backpressure holds the head, queue stops at QDEPTH
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_xfer(8'(i), prog[i]);
    start_run();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_op", 32'(opcode), 32'h2);
      check("t2_hold_pc", 32'(pc_out), 32'h0);
      tick();
    end
    check("t2_qcount",   32'(dut.q_count), 32'(QDEPTH));
    check("t2_inflight", 32'(dut.inflight_reg), 32'd0);
    issue_ready = 1'b1;
    wait_halt("t2_halt", 20);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: redirect to 2 while pc 1 transfers
    expect_xfer(8'h00, prog[0]);
    expect_xfer(8'h01, prog[1]);
    expect_xfer(8'h02, prog[2]);
    expect_xfer(8'h03, prog[3]);
    start_run();
    tick();
    tick();
    check("t3_head0", 32'(pc_out), 32'h0);
    tick();
    check("t3_head1", 32'(pc_out), 32'h1);
    redirect_en = 1'b1;
    redirect_addr = 8'h02;
    tick();
    redirect_en = 1'b0;
    check("t3_gap0", 32'(issue_valid), 32'd0);
    tick();
    check("t3_gap1", 32'(issue_valid), 32'd0);
    tick();
    check("t3_valid2", 32'(issue_valid), 32'd1);
    check("t3_pc2",    32'(pc_out), 32'h2);
    wait_halt("t3_halt", 20);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: redirect beyond end_addr halts with nothing issued
    start_run();
    redirect_en = 1'b1;
    redirect_addr = 8'h10;
    tick();
    redirect_en = 1'b0;
    check("t4_valid_a",  32'(issue_valid), 32'd0);
    check("t4_notyet",   32'(halted), 32'd0);
    tick();
    check("t4_halted",   32'(halted), 32'd1);
    check("t4_valid_b",  32'(issue_valid), 32'd0);

    // 5: single instruction at the top address, no wrap
    load_begin();
    load_write(8'hFF, 8'hA6);
    load_end();
    expect_xfer(8'hFF, 8'hA6);
    start_run();
    redirect_en = 1'b1;
    redirect_addr = 8'hFF;
    tick();
    redirect_en = 1'b0;
    tick();
    check("t5_gap", 32'(issue_valid), 32'd0);
    tick();
    check("t5_valid", 32'(issue_valid), 32'd1);
    check("t5_pc",    32'(pc_out), 32'hFF);
    tick();
    check("t5_after_valid", 32'(issue_valid), 32'd0);
    check("t5_fpc_nowrap",  32'(dut.fpc_reg), 32'h100);
    tick();
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: asynchronous reset with a full queue
    issue_ready = 1'b0;
    start_run();
    for (int k = 0; k < 4; k++) tick();
    check("t6_qfull", 32'(dut.q_count), 32'(QDEPTH));
    check("t6_valid_pre", 32'(issue_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid",  32'(issue_valid), 32'd0);
    check("t6_rst_busy",   32'(busy), 32'd0);
    check("t6_rst_halted", 32'(halted), 32'd0);
    check("t6_rst_op",     32'(opcode), 32'd0);
    check("t6_rst_pc",     32'(pc_out), 32'd0);
    #1 rst = 1'b0;
    tick();
    start_run();
    check("t6_run_halts", 32'(halted), 32'd1);
    check("t6_busy",      32'(busy), 32'd0);
    check("t6_sb_empty",  32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
